check_password: RTL and testbench

Second-stage authenticator for the access controller. Once the ID checker asserts IDOK with the user's ROM index on InternalID, this block collects a 6-digit hex password from the input switches. It fetches the stored 24-bit password for that index from the password ROM, compares the two, and asserts PswdOK on a match. Repeated failures lock entry for a fixed period. Logout, or loss of IDOK, returns the block to idle.

---
 rtl/check_password.sv | 150 +++++++++++++++
 tb/tb_check_password.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/check_password.sv
// Password stage of the access controller: collects six hex digits, fetches the
// stored password for the authenticated ID from ROM, compares, and enforces lockout.
module check_password #(
  parameter int ROM_LATENCY = 2,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  InputSwitches,
  input  logic        EnterPswd,
  input  logic        LogOutPulse,
  input  logic        IDOK,
  input  logic [4:0]  InternalID,
  input  logic [23:0] RomQ,
  output logic [4:0]  RomAddr,
  output logic        PswdOK,
  output logic        PswdFail,
  output logic        LockOut,
  output logic [2:0]  TriesLeft
);

  localparam int              WaitW    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(ROM_LATENCY - 1);
  localparam logic [2:0]      MaxTries = 3'(MAX_TRIES);
  localparam logic [31:0]     LockLast = 32'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {Idle, Digit, Fetch, Wait, Catch, Compare, Success, Locked} state_t;

  state_t           state, nextState;
  logic [2:0]       digitCnt, digitCntNext;
  logic [23:0]      enteredPswd, pswdNext;
  logic [23:0]      storedPswd, storedNext;
  logic [WaitW-1:0] waitCnt, waitCntNext;
  logic [31:0]      lockCnt, lockCntNext;
  logic [2:0]       failCount, failNext;
  logic [4:0]       romAddrNext;
  logic             failPulse;

  always_comb begin
    nextState    = state;
    digitCntNext = digitCnt;
    pswdNext     = enteredPswd;
    storedNext   = storedPswd;
    waitCntNext  = waitCnt;
    lockCntNext  = lockCnt;
    failNext     = failCount;
    romAddrNext  = RomAddr;
    failPulse    = 1'b0;
    // Lockout must run to completion, so only Locked is immune to abort/logout.
    if (state != Locked && (!IDOK || LogOutPulse)) begin
      nextState    = Idle;
      digitCntNext = '0;
      pswdNext     = '0;
      if (state == Success && IDOK) failNext = '0;
    end else begin
      case (state)
        Idle: begin
          digitCntNext = '0;
          pswdNext     = '0;
          nextState    = Digit;
        end
        Digit: begin
          if (EnterPswd) begin
            pswdNext = {enteredPswd[19:0], InputSwitches};
            if (digitCnt == 3'd5) begin
              digitCntNext = '0;
              nextState    = Fetch;
            end else begin
              digitCntNext = digitCnt + 3'd1;
            end
          end
        end
        Fetch: begin
          romAddrNext = InternalID;
          waitCntNext = '0;
          nextState   = Wait;
        end
        Wait: begin
          if (waitCnt == WaitLast) nextState = Catch;
          else waitCntNext = waitCnt + 1'b1;
        end
        Catch: begin
          storedNext = RomQ;
          nextState  = Compare;
        end
        Compare: begin
          if (enteredPswd == storedPswd) begin
            failNext  = '0;
            nextState = Success;
          end else begin
            failPulse = 1'b1;
            failNext  = failCount + 3'd1;
            if (failNext == MaxTries) begin
              lockCntNext = '0;
              nextState   = Locked;
            end else begin
              digitCntNext = '0;
              pswdNext     = '0;
              nextState    = Digit;
            end
          end
        end
        Success: nextState = Success;
        Locked: begin
          if (lockCnt == LockLast) begin
            lockCntNext = '0;
            failNext    = '0;
            nextState   = Idle;
          end else begin
            lockCntNext = lockCnt + 32'd1;
          end
        end
        default: nextState = Idle;
      endcase
    end
  end

  // Outputs are registered from next-state values so they align with the state they describe.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= Idle;
      digitCnt    <= '0;
      enteredPswd <= '0;
      storedPswd  <= '0;
      waitCnt     <= '0;
      lockCnt     <= '0;
      failCount   <= '0;
      RomAddr     <= '0;
      PswdOK      <= 1'b0;
      PswdFail    <= 1'b0;
      LockOut     <= 1'b0;
      TriesLeft   <= MaxTries;
    end else begin
      state       <= nextState;
      digitCnt    <= digitCntNext;
      enteredPswd <= pswdNext;
      storedPswd  <= storedNext;
      waitCnt     <= waitCntNext;
      lockCnt     <= lockCntNext;
      failCount   <= failNext;
      RomAddr     <= romAddrNext;
      PswdOK      <= (nextState == Success);
      PswdFail    <= failPulse;
      LockOut     <= (nextState == Locked);
      TriesLeft   <= MaxTries - failNext;
    end
  end

endmodule

// File: tb/tb_check_password.sv
// Directed bench for check_password: login, retry, logout, abort and lockout,
// against a two-stage registered ROM model.
module tb_check_password;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  InputSwitches = '0;
  logic        EnterPswd = 1'b0;
  logic        LogOutPulse = 1'b0;
  logic        IDOK = 1'b0;
  logic [4:0]  InternalID = '0;
  logic [23:0] RomQ = '0;
  logic [4:0]  RomAddr;
  logic        PswdOK, PswdFail, LockOut;
  logic [2:0]  TriesLeft;

  int checks = 0;
  int failures = 0;

  check_password #(.ROM_LATENCY(2), .MAX_TRIES(3), .LOCK_CYCLES(8)) dut (
    .Clk(Clk), .Reset(Reset), .InputSwitches(InputSwitches), .EnterPswd(EnterPswd),
    .LogOutPulse(LogOutPulse), .IDOK(IDOK), .InternalID(InternalID), .RomQ(RomQ),
    .RomAddr(RomAddr), .PswdOK(PswdOK), .PswdFail(PswdFail), .LockOut(LockOut),
    .TriesLeft(TriesLeft)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] romData(logic [4:0] a);
    case (a)
      5'd0:    romData = 24'hA54E32;
      5'd1:    romData = 24'h123456;
      5'd2:    romData = 24'hF24630;
      default: romData = 24'h000000;
    endcase
  endfunction

  // ROM with registered address and registered output.
  logic [4:0] romAddrQ = '0;
  always @(posedge Clk) begin
    romAddrQ <= RomAddr;
    RomQ     <= romData(romAddrQ);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic digit(logic [3:0] d);
    InputSwitches = d;
    EnterPswd = 1'b1;
    step(1);
    EnterPswd = 1'b0;
  endtask

  task automatic enterPswd(logic [23:0] p);
    for (int i = 5; i >= 0; i--) digit(p[i*4 +: 4]);
  endtask

  // Called one cycle after the 6th digit; result is due 5 edges later.
  task automatic expectResult(string tag, logic okExp, logic [2:0] triesExp);
    step(4);
    chk({tag, "_early"}, {30'd0, PswdOK, PswdFail}, 32'd0);
    step(1);
    chk({tag, "_ok"}, {31'd0, PswdOK}, {31'd0, okExp});
    chk({tag, "_fail"}, {31'd0, PswdFail}, {31'd0, !okExp});
    chk({tag, "_tries"}, {29'd0, TriesLeft}, {29'd0, triesExp});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      InputSwitches = 4'($urandom);
      EnterPswd     = 1'($urandom);
      LogOutPulse   = 1'($urandom);
      IDOK          = 1'($urandom);
      InternalID    = 5'($urandom);
      step(1);
      chk("rst_ok", {31'd0, PswdOK}, 32'd0);
      chk("rst_fail", {31'd0, PswdFail}, 32'd0);
      chk("rst_lock", {31'd0, LockOut}, 32'd0);
      chk("rst_addr", {27'd0, RomAddr}, 32'd0);
      chk("rst_tries", {29'd0, TriesLeft}, 32'd3);
    end
    Reset = 1'b1; EnterPswd = 1'b0; LogOutPulse = 1'b0; IDOK = 1'b0; InternalID = 5'd0;
    step(1);

    // Correct password at index 0
    IDOK = 1'b1;
    step(2);
    enterPswd(24'hA54E32);
    expectResult("good", 1'b1, 3'd3);
    chk("good_addr", {27'd0, RomAddr}, 32'd0);

    // Logout, then a partial re-entry must not authenticate
    LogOutPulse = 1'b1;
    step(1);
    LogOutPulse = 1'b0; IDOK = 1'b0;
    chk("logout_ok", {31'd0, PswdOK}, 32'd0);
    step(1);
    IDOK = 1'b1;
    step(2);
    for (int i = 5; i >= 1; i--) digit(4'(24'hA54E32 >> (i*4)));
    step(10);
    chk("partial_ok", {31'd0, PswdOK}, 32'd0);
    chk("partial_fail", {31'd0, PswdFail}, 32'd0);
    IDOK = 1'b0;
    step(1);

    // Fail then retry at index 2
    InternalID = 5'd2; IDOK = 1'b1;
    step(2);
    enterPswd(24'hF24631);
    expectResult("bad1", 1'b0, 3'd2);
    step(1);
    chk("bad1_pulse", {31'd0, PswdFail}, 32'd0);
    enterPswd(24'hF24630);
    expectResult("retry", 1'b1, 3'd3);
    chk("retry_addr", {27'd0, RomAddr}, 32'd2);
    LogOutPulse = 1'b1;
    step(1);
    LogOutPulse = 1'b0;
    step(1);

    // Abort mid-entry: partial digits must be discarded
    digit(4'hF); digit(4'h2); digit(4'h4);
    IDOK = 1'b0;
    step(1);
    IDOK = 1'b1;
    step(1);
    enterPswd(24'hF24630);
    expectResult("abort", 1'b1, 3'd3);
    LogOutPulse = 1'b1;
    step(1);
    LogOutPulse = 1'b0;
    step(1);

    // Lockout after three wrong entries; inputs ignored while locked
    enterPswd(24'h111111);
    expectResult("lk1", 1'b0, 3'd2);
    enterPswd(24'h222222);
    expectResult("lk2", 1'b0, 3'd1);
    enterPswd(24'h333333);
    expectResult("lk3", 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      chk("lock_on", {31'd0, LockOut}, 32'd1);
      InputSwitches = 4'(i);
      EnterPswd   = (i == 2 || i == 5);
      LogOutPulse = (i == 3);
      IDOK        = (i != 4);
      step(1);
    end
    EnterPswd = 1'b0; LogOutPulse = 1'b0; IDOK = 1'b1;
    chk("lock_off", {31'd0, LockOut}, 32'd0);
    chk("lock_tries", {29'd0, TriesLeft}, 32'd3);
    chk("lock_okq", {31'd0, PswdOK}, 32'd0);
    step(1);
    enterPswd(24'hF24630);
    expectResult("postlock", 1'b1, 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
